// File: rtl/dice_counter_chain_if.sv
// Handshake bundle for the dice counter chain: control/load inputs and
// the registered count, sum and status pulses.
interface dice_counter_chain_if #(
   parameter int WIDTH = 3,
   parameter int NDICE = 2,
   parameter int SUMW  = 5
);
   logic                   en;
   logic                   up;
   logic                   load;
   logic [NDICE*WIDTH-1:0] load_val;
   logic [NDICE*WIDTH-1:0] count;
   logic [SUMW-1:0]        sum;
   logic                   wrap;
   logic                   load_err;

   // Driver side (testbench or surrounding logic)
   modport master (
      output en, up, load, load_val,
      input  count, sum, wrap, load_err
   );

   // Counter side
   modport slave (
      input  en, up, load, load_val,
      output count, sum, wrap, load_err
   );
endinterface

// File: rtl/dice_counter_chain.sv
// Chain of NDICE dice (values 1..FACES) counting like an odometer.
// Die 0 steps on every enabled edge; die k steps in the same edge when all
// lower dice sit at their wrap boundary. Sum and status pulses are
// registered alongside the dice.
module dice_counter_chain #(
   parameter int FACES = 6,
   parameter int WIDTH = 3,
   parameter int NDICE = 2,
   parameter int SUMW  = 5
) (
   input  logic                 clock,
   input  logic                 reset,
   dice_counter_chain_if.slave  bus
);

   localparam logic [WIDTH-1:0] FACE_MAX = WIDTH'(FACES);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   logic [NDICE*WIDTH-1:0] count_q, count_d;
   logic [SUMW-1:0]        sum_q, sum_d;
   logic                   wrap_q, wrap_d;
   logic                   load_err_q, load_err_d;

   // Scratch values for the combinational chain walk
   logic [WIDTH-1:0]       die;
   logic [WIDTH-1:0]       digit;
   logic                   step;

   // Next-state: load sanitises digits, otherwise walk the carry/borrow chain
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would infer a latch.
      count_d    = count_q;
      wrap_d     = 1'b0;
      load_err_d = 1'b0;
      die        = '0;
      digit      = '0;
      step       = 1'b0;
      sum_d      = '0;

      if (bus.load) begin
         for (int k = 0; k < NDICE; k++) begin
            digit = bus.load_val[k*WIDTH +: WIDTH];
            if (digit == '0 || digit > FACE_MAX) begin
               count_d[k*WIDTH +: WIDTH] = ONE;
               load_err_d                = 1'b1;
            end else begin
               count_d[k*WIDTH +: WIDTH] = digit;
            end
         end
      end else if (bus.en) begin
         // NOTE: 'step' is a blocking temporary inside always_comb so each
         // loop iteration sees the carry produced by the dice below it.
         step = 1'b1;
         for (int k = 0; k < NDICE; k++) begin
            die = count_q[k*WIDTH +: WIDTH];
            if (step) begin
               if (bus.up)
                  count_d[k*WIDTH +: WIDTH] = (die == FACE_MAX) ? ONE : die + ONE;
               else
                  count_d[k*WIDTH +: WIDTH] = (die == ONE) ? FACE_MAX : die - ONE;
            end
            step = step && (die == (bus.up ? FACE_MAX : ONE));
         end
         // Carry out of the top die means every die wrapped this edge
         wrap_d = step;
      end

      for (int k = 0; k < NDICE; k++)
         sum_d = sum_d + SUMW'(count_d[k*WIDTH +: WIDTH]);
   end

   // State register with synchronous reset to all-ones dice
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so all
      // registers update together from pre-edge values.
      if (reset) begin
         count_q    <= {NDICE{ONE}};
         sum_q      <= SUMW'(NDICE);
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         sum_q      <= sum_d;
         wrap_q     <= wrap_d;
         load_err_q <= load_err_d;
      end
   end

   assign bus.count    = count_q;
   assign bus.sum      = sum_q;
   assign bus.wrap     = wrap_q;
   assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_dice_counter_chain.sv
// Bench for dice_counter_chain (FACES=6, WIDTH=3, NDICE=2). Directed
// scenarios compare against literal values; the random scenario compares
// against an odometer model holding the chain as one integer 0..FACES**NDICE-1.
module tb_dice_counter_chain;

   localparam int FACES = 6;
   localparam int WIDTH = 3;
   localparam int NDICE = 2;
   localparam int SUMW  = 5;
   localparam int NSTATES = FACES ** NDICE;

   logic clk;
   logic rst;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   int   m_v;
   logic m_wrap;
   logic m_err;

   dice_counter_chain_if #(.WIDTH(WIDTH), .NDICE(NDICE), .SUMW(SUMW)) bus ();

   dice_counter_chain #(
      .FACES(FACES), .WIDTH(WIDTH), .NDICE(NDICE), .SUMW(SUMW)
   ) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Die k of the odometer value v, in 1..FACES
   function automatic int model_die(input int v, input int k);
      return (v / (FACES ** k)) % FACES + 1;
   endfunction

   function automatic logic [NDICE*WIDTH-1:0] model_count(input int v);
      logic [NDICE*WIDTH-1:0] c;
      c = '0;
      for (int k = 0; k < NDICE; k++) c[k*WIDTH +: WIDTH] = WIDTH'(model_die(v, k));
      return c;
   endfunction

   function automatic logic [SUMW-1:0] model_sum(input int v);
      int s;
      s = 0;
      for (int k = 0; k < NDICE; k++) s += model_die(v, k);
      return SUMW'(s);
   endfunction

   // Drive one edge's inputs, advance the model, settle past the edge
   task automatic apply(input logic r, input logic e, input logic u,
                        input logic l, input logic [NDICE*WIDTH-1:0] lv);
      int d;
      @(negedge clk);
      rst = r; bus.en = e; bus.up = u; bus.load = l; bus.load_val = lv;
      @(posedge clk);
      if (r) begin
         m_v = 0; m_wrap = 1'b0; m_err = 1'b0;
      end else if (l) begin
         m_v = 0; m_wrap = 1'b0; m_err = 1'b0;
         for (int k = 0; k < NDICE; k++) begin
            d = int'(lv[k*WIDTH +: WIDTH]);
            if (d < 1 || d > FACES) begin d = 1; m_err = 1'b1; end
            m_v += (d - 1) * (FACES ** k);
         end
      end else if (e) begin
         m_err = 1'b0;
         if (u) begin m_wrap = (m_v == NSTATES - 1); m_v = (m_v + 1) % NSTATES; end
         else   begin m_wrap = (m_v == 0);           m_v = (m_v + NSTATES - 1) % NSTATES; end
      end else begin
         m_wrap = 1'b0; m_err = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      apply(1'b1, 1'b1, 1'b1, 1'b1, 6'b101_011);
      vectors++;
      if ({bus.count, bus.sum, bus.wrap, bus.load_err} !== {6'b001_001, 5'd2, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset: got count=%b sum=%0d wrap=%b err=%b, expected count=001001 sum=2 wrap=0 err=0",
                  bus.count, bus.sum, bus.wrap, bus.load_err);
      end
   endtask

   task automatic test_count_up();
      logic [5:0] exp_c;
      apply(1'b1, 1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 6; i++) begin
         apply(1'b0, 1'b1, 1'b1, 1'b0, '0);
         exp_c = (i < 5) ? {3'd1, 3'(i + 2)} : 6'b010_001;
         vectors++;
         if ({bus.count, bus.sum, bus.wrap} !== {exp_c, 5'(i < 5 ? i + 3 : 3), 1'b0}) begin
            miscompares++;
            $display("FAIL count_up step %0d: got count=%b sum=%0d wrap=%b, expected count=%b",
                     i, bus.count, bus.sum, bus.wrap, exp_c);
         end
      end
   endtask

   task automatic test_wrap_down();
      apply(1'b1, 1'b0, 1'b0, 1'b0, '0);
      apply(1'b0, 1'b1, 1'b0, 1'b0, '0);
      vectors++;
      if ({bus.count, bus.sum, bus.wrap} !== {6'b110_110, 5'd12, 1'b1}) begin
         miscompares++;
         $display("FAIL wrap_down: got count=%b sum=%0d wrap=%b, expected count=110110 sum=12 wrap=1",
                  bus.count, bus.sum, bus.wrap);
      end
      apply(1'b0, 1'b0, 1'b0, 1'b0, '0);
      vectors++;
      if ({bus.count, bus.sum, bus.wrap} !== {6'b110_110, 5'd12, 1'b0}) begin
         miscompares++;
         $display("FAIL wrap_down_hold: got count=%b sum=%0d wrap=%b, expected count=110110 sum=12 wrap=0",
                  bus.count, bus.sum, bus.wrap);
      end
   endtask

   task automatic test_load();
      apply(1'b0, 1'b0, 1'b0, 1'b1, 6'b101_011);
      vectors++;
      if ({bus.count, bus.sum, bus.load_err} !== {6'b101_011, 5'd8, 1'b0}) begin
         miscompares++;
         $display("FAIL load_ok: got count=%b sum=%0d err=%b, expected count=101011 sum=8 err=0",
                  bus.count, bus.sum, bus.load_err);
      end
      apply(1'b0, 1'b0, 1'b0, 1'b1, 6'b111_000);
      vectors++;
      if ({bus.count, bus.sum, bus.load_err} !== {6'b001_001, 5'd2, 1'b1}) begin
         miscompares++;
         $display("FAIL load_bad: got count=%b sum=%0d err=%b, expected count=001001 sum=2 err=1",
                  bus.count, bus.sum, bus.load_err);
      end
      apply(1'b0, 1'b0, 1'b0, 1'b0, '0);
      vectors++;
      if ({bus.count, bus.load_err} !== {6'b001_001, 1'b0}) begin
         miscompares++;
         $display("FAIL load_err_pulse: got count=%b err=%b, expected count=001001 err=0",
                  bus.count, bus.load_err);
      end
   endtask

   task automatic test_up_wrap_priority();
      apply(1'b0, 1'b0, 1'b0, 1'b1, 6'b110_110);
      apply(1'b0, 1'b1, 1'b1, 1'b0, '0);
      vectors++;
      if ({bus.count, bus.sum, bus.wrap} !== {6'b001_001, 5'd2, 1'b1}) begin
         miscompares++;
         $display("FAIL up_wrap: got count=%b sum=%0d wrap=%b, expected count=001001 sum=2 wrap=1",
                  bus.count, bus.sum, bus.wrap);
      end
      apply(1'b0, 1'b1, 1'b1, 1'b1, 6'b100_010);
      vectors++;
      if ({bus.count, bus.sum, bus.wrap, bus.load_err} !== {6'b100_010, 5'd6, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL load_over_en: got count=%b sum=%0d wrap=%b err=%b, expected count=100010 sum=6 wrap=0 err=0",
                  bus.count, bus.sum, bus.wrap, bus.load_err);
      end
   endtask

   task automatic test_reset_mid();
      apply(1'b0, 1'b0, 1'b0, 1'b1, 6'b011_100);
      apply(1'b1, 1'b1, 1'b1, 1'b1, 6'b101_101);
      vectors++;
      if ({bus.count, bus.sum, bus.wrap, bus.load_err} !== {6'b001_001, 5'd2, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_mid: got count=%b sum=%0d wrap=%b err=%b, expected count=001001 sum=2 wrap=0 err=0",
                  bus.count, bus.sum, bus.wrap, bus.load_err);
      end
   endtask

   task automatic test_random();
      logic r, e, u, l;
      logic [NDICE*WIDTH-1:0] lv;
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(31) == 0);
         l  = ($urandom_range(7) == 0);
         e  = ($urandom_range(3) != 0);
         u  = ($urandom_range(3) != 0) ^ (i >= 200);
         lv = NDICE*WIDTH'($urandom);
         apply(r, e, u, l, lv);
         vectors++;
         if ({bus.count, bus.sum, bus.wrap, bus.load_err} !==
             {model_count(m_v), model_sum(m_v), m_wrap, m_err}) begin
            miscompares++;
            $display("FAIL random %0d: got count=%b sum=%0d wrap=%b err=%b, expected count=%b sum=%0d wrap=%b err=%b",
                     i, bus.count, bus.sum, bus.wrap, bus.load_err,
                     model_count(m_v), model_sum(m_v), m_wrap, m_err);
         end
      end
   endtask

   initial begin
      rst = 1'b0; bus.en = 1'b0; bus.up = 1'b0; bus.load = 1'b0; bus.load_val = '0;
      m_v = 0; m_wrap = 1'b0; m_err = 1'b0;
      test_reset();
      test_count_up();
      test_wrap_down();
      test_load();
      test_up_wrap_priority();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dice_counter_chain.md
DICE_COUNTER_CHAIN -- requirements
Module: dice_counter_chain

Interface
REQ-001 SHALL have parameter FACES, default 6, meaning highest face value of each die (legal range 2..2**WIDTH-1).
REQ-002 SHALL have parameter WIDTH, default 3, meaning bits per die value.
REQ-003 SHALL have parameter NDICE, default 2, meaning number of chained dice (legal range 1..8).
REQ-004 SHALL have parameter SUMW, default 5, meaning width of sum output (must hold NDICE*FACES).
REQ-005 SHALL have port clock  input  1  sole clock, all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en  input  1  count enable; advance the chain one step per enabled edge.
REQ-008 SHALL have port up  input  1  direction; 1 = increment, 0 = decrement.
REQ-009 SHALL have port load  input  1  synchronous parallel load request.
REQ-010 SHALL have port load_val  input  NDICE*WIDTH  values to load; die k in bits [k*WIDTH +: WIDTH].
REQ-011 SHALL have port count  output  NDICE*WIDTH  registered die values, same packing as load_val; die 0 least significant.
REQ-012 SHALL have port sum  output  SUMW  registered sum of all die values.
REQ-013 SHALL have port wrap  output  1  one-cycle pulse on full-chain wrap-around.
REQ-014 SHALL have port load_err  output  1  one-cycle pulse when a load contained an out-of-range digit.

Function
REQ-015 SHALL keep every die value in 1..FACES at all times outside of reset.
REQ-016 SHALL apply priority reset > load > en; en=0 and load=0 holds all state, and wrap and load_err are 0.
REQ-017 SHALL on en=1, up=1 increment die 0; FACES wraps to 1.
REQ-018 SHALL on en=1, up=0 decrement die 0; 1 wraps to FACES.
REQ-019 SHALL step die k (k>0) in the same edge only when every lower die is at FACES (up) or at 1 (down), i.e. odometer carry/borrow, with no ripple latency.
REQ-020 SHALL assert wrap for exactly the cycle after an enabled edge where all dice wrapped: all FACES -> all 1 (up) or all 1 -> all FACES (down).
REQ-021 SHALL on load=1 copy each load_val digit to its die; a digit of 0 or >FACES SHALL load as 1.
REQ-022 SHALL assert load_err for one cycle after a load in which any digit was replaced; wrap SHALL be 0 after a load.
REQ-023 SHALL ignore en and up in a load cycle.
REQ-024 SHALL update sum on the same edge as count so sum always equals the arithmetic sum of the present die values (zero-extended to SUMW).
REQ-025 SHALL sample up per edge; a direction change between consecutive enabled edges takes effect immediately with no extra step.
REQ-026 SHALL use count latency of one edge: the value after edge N reflects inputs sampled at edge N.
REQ-027 SHALL produce no X on any output after the first reset edge, regardless of en/up/load values.

Reset
REQ-028 SHALL on reset=1 at a rising edge set every die to 1, sum to NDICE, wrap to 0, load_err to 0.
REQ-029 SHALL honour reset mid-operation, overriding a simultaneous load or en in that cycle.
REQ-030 SHALL leave outputs undefined only before the first reset edge; no initial-value dependence.

Verification (FACES=6, WIDTH=3, NDICE=2)
REQ-031 SHALL cover reset: reset=1 one edge -> count=6'b001_001, sum=2, wrap=0, load_err=0.
REQ-032 SHALL cover count-up: from reset, en=1 up=1 for 6 edges -> die0 1,2,3,4,5,6 then 1 and die1 1 to 2 on the 6th edge; count=6'b010_001, sum=3.
REQ-033 SHALL cover wrap-down: from reset, en=1 up=0 one edge -> count=6'b110_110, sum=12, wrap=1 for one cycle then 0 on a following held cycle.
REQ-034 SHALL cover load: load=1 load_val=6'b101_011 -> count=6'b101_011, sum=8, load_err=0; then load_val=6'b111_000 -> count=6'b001_001, load_err=1 for one cycle.
REQ-035 SHALL cover up-wrap and priority: load 6'b110_110 then en=1 up=1 -> count=6'b001_001, wrap=1; load=1 with en=1 -> loaded value, no step.
REQ-036 SHALL cover reset mid-count: reset=1 with en=1 load=1 at count 6'b011_100 -> count=6'b001_001, sum=2.
